// File: rtl/sram_arb_pkg.sv
// Shared types and widths for the SRAM port arbiter.
package sram_arb_pkg;

  localparam int unsigned WORD_WIDTH     = 32;
  localparam int unsigned BANK_WIDTH     = 16;
  localparam int unsigned BYTES_PER_BANK = 2;

  typedef enum logic [1:0] {
    OWNER_NONE,
    OWNER_IFETCH,
    OWNER_DMEM
  } owner_t;

endpackage

// File: rtl/sram_arb_grant.sv
// Tie-break and ack generation for the fetch and data ports.
// SRAM_ARB_ROUND_ROBIN_EN selects round-robin ties; otherwise data wins with a starvation counter.
module sram_arb_grant #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic ifetch_req,
  input  logic dmem_req,
  output logic ifetch_ack,
  output logic dmem_ack
);

  logic fetch_wins_tie;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  // Low means fetch was granted last, which is also the reset state.
  logic last_dmem_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_dmem_q <= 1'b0;
    end else if (ifetch_ack) begin
      last_dmem_q <= 1'b0;
    end else if (dmem_ack) begin
      last_dmem_q <= 1'b1;
    end
  end

  assign fetch_wins_tie = last_dmem_q;
`else
  localparam int unsigned CntWidth = $clog2(STARVE_LIMIT + 1);

  logic [CntWidth-1:0] starve_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_q <= '0;
    end else if (ifetch_req && !ifetch_ack) begin
      if (starve_cnt_q != CntWidth'(STARVE_LIMIT)) begin
        starve_cnt_q <= starve_cnt_q + 1'b1;
      end
    end else begin
      starve_cnt_q <= '0;
    end
  end

  assign fetch_wins_tie = (starve_cnt_q == CntWidth'(STARVE_LIMIT));
`endif

  always_comb begin
    ifetch_ack = !reset && ifetch_req && (!dmem_req || fetch_wins_tie);
    dmem_ack   = !reset && dmem_req && !(ifetch_req && fetch_wins_tie);
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Two-port front end for the split 16-bit SRAM banks: RAM muxing, byte-enable split, read pipeline.
// Tie-break policy is selected by SRAM_ARB_ROUND_ROBIN_EN (see sram_arb_grant).
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 14,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ifetch_req,
  input  logic [ADDR_WIDTH-1:0]     ifetch_addr,
  output logic                      ifetch_ack,
  output logic                      ifetch_rvalid,
  output logic [WORD_WIDTH-1:0]     ifetch_rdata,
  input  logic                      dmem_req,
  input  logic [ADDR_WIDTH-1:0]     dmem_addr,
  input  logic [3:0]                dmem_we,
  input  logic [WORD_WIDTH-1:0]     dmem_wdata,
  output logic                      dmem_ack,
  output logic                      dmem_rvalid,
  output logic [WORD_WIDTH-1:0]     dmem_rdata,
  output logic [ADDR_WIDTH-1:0]     ram_addr,
  output logic [BANK_WIDTH-1:0]     ram_din_hi,
  output logic [BANK_WIDTH-1:0]     ram_din_lo,
  output logic [BYTES_PER_BANK-1:0] ram_we_hi,
  output logic [BYTES_PER_BANK-1:0] ram_we_lo,
  input  logic [BANK_WIDTH-1:0]     ram_dout_hi,
  input  logic [BANK_WIDTH-1:0]     ram_dout_lo
);

  logic [ADDR_WIDTH-1:0] addr_q;
  owner_t                grant_owner;
  owner_t                owner_q;
  logic                  ifetch_rvalid_q;
  logic                  dmem_rvalid_q;
  logic [WORD_WIDTH-1:0] ifetch_rdata_q;
  logic [WORD_WIDTH-1:0] dmem_rdata_q;

  sram_arb_grant #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_grant (
    .clk       (clk),
    .reset     (reset),
    .ifetch_req(ifetch_req),
    .dmem_req  (dmem_req),
    .ifetch_ack(ifetch_ack),
    .dmem_ack  (dmem_ack)
  );

  always_comb begin
    ram_addr    = addr_q;
    ram_din_hi  = '0;
    ram_din_lo  = '0;
    ram_we_hi   = '0;
    ram_we_lo   = '0;
    grant_owner = OWNER_NONE;
    if (dmem_ack) begin
      ram_addr   = dmem_addr;
      ram_din_hi = dmem_wdata[WORD_WIDTH-1:BANK_WIDTH];
      ram_din_lo = dmem_wdata[BANK_WIDTH-1:0];
      ram_we_hi  = dmem_we[3:2];
      ram_we_lo  = dmem_we[1:0];
      if (dmem_we == '0) begin
        grant_owner = OWNER_DMEM;
      end
    end else if (ifetch_ack) begin
      ram_addr    = ifetch_addr;
      grant_owner = OWNER_IFETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q          <= '0;
      owner_q         <= OWNER_NONE;
      ifetch_rvalid_q <= 1'b0;
      dmem_rvalid_q   <= 1'b0;
      ifetch_rdata_q  <= '0;
      dmem_rdata_q    <= '0;
    end else begin
      if (ifetch_ack || dmem_ack) begin
        addr_q <= ram_addr;
      end
      owner_q         <= grant_owner;
      ifetch_rvalid_q <= (owner_q == OWNER_IFETCH);
      dmem_rvalid_q   <= (owner_q == OWNER_DMEM);
      if (owner_q == OWNER_IFETCH) begin
        ifetch_rdata_q <= {ram_dout_hi, ram_dout_lo};
      end
      if (owner_q == OWNER_DMEM) begin
        dmem_rdata_q <= {ram_dout_hi, ram_dout_lo};
      end
    end
  end

  // A read captured just before reset must not surface while reset is high.
  assign ifetch_rvalid = ifetch_rvalid_q && !reset;
  assign dmem_rvalid   = dmem_rvalid_q && !reset;
  assign ifetch_rdata  = ifetch_rdata_q;
  assign dmem_rdata    = dmem_rdata_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomized bench for sram_port_arbiter against a transaction-level reference model.
// Build with SRAM_ARB_ROUND_ROBIN_EN to check the round-robin variant.
module tb_sram_port_arbiter;

  localparam int unsigned AW    = 14;
  localparam int          LIMIT = 4;

  logic          clk;
  logic          reset;
  logic          ifetch_req;
  logic [AW-1:0] ifetch_addr;
  logic          ifetch_ack;
  logic          ifetch_rvalid;
  logic [31:0]   ifetch_rdata;
  logic          dmem_req;
  logic [AW-1:0] dmem_addr;
  logic [3:0]    dmem_we;
  logic [31:0]   dmem_wdata;
  logic          dmem_ack;
  logic          dmem_rvalid;
  logic [31:0]   dmem_rdata;
  logic [AW-1:0] ram_addr;
  logic [15:0]   ram_din_hi;
  logic [15:0]   ram_din_lo;
  logic [1:0]    ram_we_hi;
  logic [1:0]    ram_we_lo;
  logic [15:0]   ram_dout_hi;
  logic [15:0]   ram_dout_lo;

  sram_port_arbiter #(
    .ADDR_WIDTH  (AW),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ifetch_req   (ifetch_req),
    .ifetch_addr  (ifetch_addr),
    .ifetch_ack   (ifetch_ack),
    .ifetch_rvalid(ifetch_rvalid),
    .ifetch_rdata (ifetch_rdata),
    .dmem_req     (dmem_req),
    .dmem_addr    (dmem_addr),
    .dmem_we      (dmem_we),
    .dmem_wdata   (dmem_wdata),
    .dmem_ack     (dmem_ack),
    .dmem_rvalid  (dmem_rvalid),
    .dmem_rdata   (dmem_rdata),
    .ram_addr     (ram_addr),
    .ram_din_hi   (ram_din_hi),
    .ram_din_lo   (ram_din_lo),
    .ram_we_hi    (ram_we_hi),
    .ram_we_lo    (ram_we_lo),
    .ram_dout_hi  (ram_dout_hi),
    .ram_dout_lo  (ram_dout_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Banked RAM model with a backdoor port for preloading contents.
  logic [31:0]   mem [0:(1<<AW)-1];
  logic          bd_en;
  logic [AW-1:0] bd_addr;
  logic [31:0]   bd_data;

  always @(posedge clk) begin
    ram_dout_hi <= mem[ram_addr][31:16];
    ram_dout_lo <= mem[ram_addr][15:0];
    if (bd_en) begin
      mem[bd_addr] <= bd_data;
    end else begin
      if (ram_we_hi[1]) mem[ram_addr][31:24] <= ram_din_hi[15:8];
      if (ram_we_hi[0]) mem[ram_addr][23:16] <= ram_din_hi[7:0];
      if (ram_we_lo[1]) mem[ram_addr][15:8]  <= ram_din_lo[15:8];
      if (ram_we_lo[0]) mem[ram_addr][7:0]   <= ram_din_lo[7:0];
    end
  end

  // Reference model: word memory, pending read queue, arbitration bookkeeping.
  typedef struct {
    int          due;
    bit          is_dmem;
    logic [31:0] data;
  } rd_t;

  logic [31:0]   ref_mem [0:(1<<AW)-1];
  rd_t           pend[$];
  int            cyc;
  int            starve;
  bit            last_was_dmem;
  logic [AW-1:0] exp_addr;
  logic [31:0]   exp_if_rdata;
  logic [31:0]   exp_d_rdata;
  bit            m_if_ack;
  bit            m_d_ack;
  int            checks;
  int            errors;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", tag, cyc, got, exp);
    end
  endtask

  // Called once per cycle with inputs stable, away from the clock edge.
  task automatic eval();
    bit          tie_fetch;
    bit          rv_if;
    bit          rv_d;
    logic [1:0]  e_we_hi;
    logic [1:0]  e_we_lo;
    rd_t         r;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    tie_fetch = last_was_dmem;
`else
    tie_fetch = (starve == LIMIT);
`endif
    m_if_ack = !reset && ifetch_req && (!dmem_req || tie_fetch);
    m_d_ack  = !reset && dmem_req && !m_if_ack;
    check_eq("ifetch_ack", 32'(ifetch_ack), 32'(m_if_ack));
    check_eq("dmem_ack", 32'(dmem_ack), 32'(m_d_ack));

    rv_if = 1'b0;
    rv_d  = 1'b0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      r = pend.pop_front();
      if (r.is_dmem) begin
        rv_d        = !reset;
        exp_d_rdata = r.data;
      end else begin
        rv_if        = !reset;
        exp_if_rdata = r.data;
      end
    end
    check_eq("ifetch_rvalid", 32'(ifetch_rvalid), 32'(rv_if));
    check_eq("dmem_rvalid", 32'(dmem_rvalid), 32'(rv_d));
    check_eq("ifetch_rdata", ifetch_rdata, exp_if_rdata);
    check_eq("dmem_rdata", dmem_rdata, exp_d_rdata);

    e_we_hi = 2'b00;
    e_we_lo = 2'b00;
    if (m_d_ack) begin
      exp_addr = dmem_addr;
      e_we_hi  = dmem_we[3:2];
      e_we_lo  = dmem_we[1:0];
      check_eq("ram_din_hi", 32'(ram_din_hi), 32'(dmem_wdata[31:16]));
      check_eq("ram_din_lo", 32'(ram_din_lo), 32'(dmem_wdata[15:0]));
    end else if (m_if_ack) begin
      exp_addr = ifetch_addr;
    end
    check_eq("ram_addr", 32'(ram_addr), 32'(exp_addr));
    check_eq("ram_we_hi", 32'(ram_we_hi), 32'(e_we_hi));
    check_eq("ram_we_lo", 32'(ram_we_lo), 32'(e_we_lo));

    if (m_d_ack && dmem_we != 4'b0000) begin
      for (int b = 0; b < 4; b++) begin
        if (dmem_we[b]) ref_mem[dmem_addr][8*b +: 8] = dmem_wdata[8*b +: 8];
      end
    end else if (m_d_ack) begin
      pend.push_back('{cyc + 2, 1'b1, ref_mem[dmem_addr]});
    end
    if (m_if_ack) pend.push_back('{cyc + 2, 1'b0, ref_mem[ifetch_addr]});

    if (reset) begin
      starve        = 0;
      last_was_dmem = 1'b0;
      pend.delete();
      exp_addr      = '0;
      exp_if_rdata  = '0;
      exp_d_rdata   = '0;
    end else begin
      if (ifetch_req && !m_if_ack) starve = (starve < LIMIT) ? starve + 1 : LIMIT;
      else starve = 0;
      if (m_if_ack) last_was_dmem = 1'b0;
      else if (m_d_ack) last_was_dmem = 1'b1;
    end
    cyc++;
  endtask

  task automatic drive(input bit rst, input bit ireq, input logic [AW-1:0] ia, input bit dreq,
                       input logic [AW-1:0] da, input logic [3:0] we, input logic [31:0] wd);
    @(negedge clk);
    reset       = rst;
    ifetch_req  = ireq;
    ifetch_addr = ia;
    dmem_req    = dreq;
    dmem_addr   = da;
    dmem_we     = we;
    dmem_wdata  = wd;
    #1;
    eval();
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, 1'b0, '0, 4'b0000, 32'h0);
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_ifetch_ack"}, 32'(ifetch_ack), 32'h0);
    check_eq({tag, "_dmem_ack"}, 32'(dmem_ack), 32'h0);
    check_eq({tag, "_ifetch_rvalid"}, 32'(ifetch_rvalid), 32'h0);
    check_eq({tag, "_dmem_rvalid"}, 32'(dmem_rvalid), 32'h0);
    check_eq({tag, "_ifetch_rdata"}, ifetch_rdata, 32'h0);
    check_eq({tag, "_dmem_rdata"}, dmem_rdata, 32'h0);
    check_eq({tag, "_ram_addr"}, 32'(ram_addr), 32'h0);
    check_eq({tag, "_ram_we"}, 32'({ram_we_hi, ram_we_lo}), 32'h0);
    check_eq({tag, "_ram_din"}, {ram_din_hi, ram_din_lo}, 32'h0);
  endtask

  initial begin
    bit            ireq;
    bit            dreq;
    logic [AW-1:0] ia;
    logic [AW-1:0] da;
    logic [3:0]    we;
    logic [31:0]   wd;
    bit            rst;

    checks = 0;
    errors = 0;
    cyc = 0;
    starve = 0;
    last_was_dmem = 1'b0;
    exp_addr = '0;
    exp_if_rdata = '0;
    exp_d_rdata = '0;
    reset = 1'b1;
    ifetch_req = 1'b0;
    ifetch_addr = '0;
    dmem_req = 1'b0;
    dmem_addr = '0;
    dmem_we = '0;
    dmem_wdata = '0;
    bd_en = 1'b0;
    bd_addr = '0;
    bd_data = '0;

    // Preload the low address range during reset.
    for (int i = 0; i < 64; i++) begin
      bd_en   = 1'b1;
      bd_addr = AW'(i);
      bd_data = (i == 16) ? 32'h12345678 : $urandom;
      ref_mem[i] = bd_data;
      drive(1'b1, 1'b0, '0, 1'b0, '0, 4'b0000, 32'h0);
    end
    bd_en = 1'b0;
    check_reset_values("rst");

    // Fetch read of 0x010.
    drive(1'b0, 1'b1, AW'(16), 1'b0, '0, 4'b0000, 32'h0);
    check_eq("t1_ack", 32'(ifetch_ack), 32'h1);
    check_eq("t1_ram_addr", 32'(ram_addr), 32'h10);
    idle();
    check_eq("t1_no_early_rvalid", 32'(ifetch_rvalid), 32'h0);
    idle();
    check_eq("t1_rvalid", 32'(ifetch_rvalid), 32'h1);
    check_eq("t1_rdata", ifetch_rdata, 32'h12345678);

    // Partial write then read-back of 0x020.
    drive(1'b0, 1'b0, '0, 1'b1, AW'(32), 4'b0110, 32'hAABBCCDD);
    check_eq("t2_we_hi", 32'(ram_we_hi), 32'h1);
    check_eq("t2_we_lo", 32'(ram_we_lo), 32'h2);
    check_eq("t2_din_hi", 32'(ram_din_hi), 32'hAABB);
    check_eq("t2_din_lo", 32'(ram_din_lo), 32'hCCDD);
    drive(1'b0, 1'b0, '0, 1'b1, AW'(32), 4'b0000, 32'h0);
    idle();
    check_eq("t2_no_write_rvalid", 32'(dmem_rvalid), 32'h0);
    idle();
    check_eq("t2_rvalid", 32'(dmem_rvalid), 32'h1);
    check_eq("t2_written_bytes", 32'(dmem_rdata[23:8]), 32'hBBCC);

    // Both ports requesting continuously from a fresh reset.
    drive(1'b1, 1'b0, '0, 1'b0, '0, 4'b0000, 32'h0);
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1, AW'(i), 1'b1, AW'(i + 40), 4'b0000, 32'h0);
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      check_eq("t3_pattern_ifetch", 32'(ifetch_ack), 32'((i % 2) == 1));
`else
      check_eq("t3_pattern_ifetch", 32'(ifetch_ack), 32'((i % 5) == 4));
`endif
    end
    idle();
    idle();

    // Alternating single-port reads stream without bubbles.
    for (int i = 0; i < 8; i++) begin
      if (i < 6 && (i % 2) == 0) drive(1'b0, 1'b1, AW'(1), 1'b0, '0, 4'b0000, 32'h0);
      else if (i < 6) drive(1'b0, 1'b0, '0, 1'b1, AW'(2), 4'b0000, 32'h0);
      else idle();
      if (i >= 2) begin
        check_eq("t4_ifetch_rvalid", 32'(ifetch_rvalid), 32'((i % 2) == 0));
        check_eq("t4_dmem_rvalid", 32'(dmem_rvalid), 32'((i % 2) == 1));
      end
    end

    // Reset right after a fetch ack drops the read.
    drive(1'b0, 1'b1, AW'(5), 1'b0, '0, 4'b0000, 32'h0);
    check_eq("t5_ack", 32'(ifetch_ack), 32'h1);
    drive(1'b1, 1'b0, '0, 1'b0, '0, 4'b0000, 32'h0);
    idle();
    check_reset_values("t5");
    idle();
    check_eq("t5_no_late_rvalid", 32'(ifetch_rvalid), 32'h0);

    // Randomized traffic with held requests, drops and occasional resets.
    ireq = 1'b0;
    dreq = 1'b0;
    ia = '0;
    da = '0;
    we = '0;
    wd = '0;
    for (int i = 0; i < 3000; i++) begin
      if (!ireq || m_if_ack) begin
        ireq = ($urandom_range(0, 99) < 60);
        ia   = AW'($urandom_range(0, 31));
      end else if ($urandom_range(0, 99) < 5) begin
        ireq = 1'b0;
      end
      if (!dreq || m_d_ack) begin
        dreq = ($urandom_range(0, 99) < 60);
        da   = AW'($urandom_range(0, 31));
        we   = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
        wd   = $urandom;
      end else if ($urandom_range(0, 99) < 5) begin
        dreq = 1'b0;
      end
      rst = ($urandom_range(0, 99) == 0);
      drive(rst, ireq, ia, dreq, da, we, wd);
    end
    idle();
    idle();
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Upstream stage of the on-chip SRAM: arbitrates between the instruction-fetch port and the data-memory port of the RISC-V core and drives one shared 32-bit word access per cycle into the two 16-bit single-port RAM banks, high and low. It splits byte write enables across the banks and pipelines read data back to the port that issued the read. Reads return with a fixed latency.

## Interface
Parameters:
- ADDR_WIDTH, 14, 32-bit word address width; shared by both RAM banks.
- STARVE_LIMIT, 4, number of consecutive denied fetch-request cycles after which fetch wins (fixed-priority mode only).

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high.
- ifetch_req  in  1  fetch read request; held until acked.
- ifetch_addr  in  ADDR_WIDTH  fetch word address.
- ifetch_ack  out  1  request granted this cycle.
- ifetch_rvalid  out  1  one-cycle pulse, fetch read data valid.
- ifetch_rdata  out  32  fetch read data.
- dmem_req  in  1  data request; held until acked.
- dmem_addr  in  ADDR_WIDTH  data word address.
- dmem_we  in  4  byte write enables; 0 = read.
- dmem_wdata  in  32  write data.
- dmem_ack  out  1  request granted this cycle.
- dmem_rvalid  out  1  one-cycle pulse, data read valid.
- dmem_rdata  out  32  data read data.
- ram_addr  out  ADDR_WIDTH  address to both banks.
- ram_din_hi  out  16  bytes 3:2 write data.
- ram_din_lo  out  16  bytes 1:0 write data.
- ram_we_hi  out  2  byte enables, high bank.
- ram_we_lo  out  2  byte enables, low bank.
- ram_dout_hi  in  16  high bank read data; valid the cycle after the address is presented.
- ram_dout_lo  in  16  low bank read data.

## Operation
- At most one grant per cycle. ack is combinational from req and the arbitration state. The granted port's address, write data, and byte enables pass combinationally to the RAM in the same cycle.
- With no grant: ram_we_* = 0 and ram_addr holds its last granted value.
- Fetch grants never write. A data grant with dmem_we != 0 is a write and produces no rvalid. dmem_we[1:0] drives ram_we_lo and dmem_we[3:2] drives ram_we_hi.
- Default fixed priority: data wins ties.
  - starve_cnt increments on every cycle with ifetch_req=1 and ifetch_ack=0.
  - starve_cnt clears on a fetch grant or when ifetch_req=0.
  - When starve_cnt == STARVE_LIMIT, fetch wins the next tie.
  - starve_cnt saturates and never wraps.
- Read pipeline:
  - Stage-1 register records the owner (NONE/IFETCH/DMEM) of a read granted in cycle N.
  - In cycle N+1, {ram_dout_hi, ram_dout_lo} is captured into the owner's rdata register.
  - The owner's rvalid pulses in cycle N+2.
- The rdata registers hold their value until the next capture. Back-to-back reads from alternating ports stream at one per cycle with no bubbles.
- A write in cycle N followed by a read of the same address in cycle N+1 returns the new data.
- Reset clears all state. Any in-flight read is dropped and no rvalid is issued for it.

## Timing
- Reset values: ifetch_ack, dmem_ack, both rvalid = 0; both rdata = 0; ram_addr = 0; ram_we_* = 0; ram_din_* = 0; starve_cnt = 0; owner = NONE.
- Read latency is ack cycle + 2 to rvalid. Throughput is one access per cycle.
- rvalid is never asserted in the cycle reset is high or in the cycle after.
- A request deasserted without an ack is legal; no access is performed.

## Configuration
- SRAM_ARB_ROUND_ROBIN_EN defined: on a tie, the port not granted most recently wins. A last-grant flag resets to IFETCH, so data wins the first tie after reset. STARVE_LIMIT is ignored and starve_cnt is not built.
- Undefined: fixed data priority with the starvation counter, as described in Operation.

## Structure
- Package sram_arb_pkg holds:
  - owner_t enum {OWNER_NONE, OWNER_IFETCH, OWNER_DMEM}
  - constants WORD_WIDTH=32, BANK_WIDTH=16, BYTES_PER_BANK=2
- Sub-module sram_arb_grant holds the tie-break logic, starve_cnt or last-grant flag, and ack generation.
- The top level holds the RAM muxing, byte-enable split, owner pipeline, and rdata capture.

## Test plan
- Reset, then fetch read of addr 0x010 with RAM returning 0x1234/0x5678 -> ifetch_ack in cycle 0, ifetch_rvalid in cycle 2, ifetch_rdata=0x12345678.
- Data write to 0x020 with we=4'b0110 and wdata=0xAABBCCDD -> ram_we_hi=2'b01, ram_we_lo=2'b10, din_hi=0xAABB, din_lo=0xCCDD, no dmem_rvalid. A read of 0x020 in the next cycle returns the written bytes.
- Both ports requesting continuously, fixed mode, STARVE_LIMIT=4 -> dmem acked 4 cycles, ifetch acked on the 5th, pattern repeats.
- Same stimulus with SRAM_ARB_ROUND_ROBIN_EN -> grants alternate dmem, ifetch, dmem, and so on.
- Alternating reads with fetch at 0x001 and data at 0x002 on consecutive cycles -> rvalids alternate with no gaps, and each carries its own address's data.
- Reset asserted the cycle after a fetch ack -> no ifetch_rvalid, and all outputs at reset values.
